// File: rtl/video_umul_arb_pkg.sv
// Shared types and helpers for the video-domain multiplier arbiter.
//   state_t   : arbiter FSM states
//   NREQ_MAX  : largest supported requester count
//   IDXW      : width of a requester index
//   rr_pick   : round-robin choice of the first request at or after a pointer
package video_umul_arb_pkg;

    localparam int NREQ_MAX = 8;
    localparam int IDXW     = $clog2(NREQ_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Two scans folded into one loop: 'hi' is the first request at or after
    // ptr, 'lo' the first request overall. When nothing sits at or after ptr
    // the search wraps, and the wrapped winner is simply the lowest request.
    function automatic logic [IDXW-1:0] rr_pick(
        input logic [NREQ_MAX-1:0] req,
        input logic [IDXW-1:0]     ptr,
        input int                  nreq
    );
        logic [IDXW-1:0] hi;
        logic [IDXW-1:0] lo;
        logic            hi_found;
        logic            lo_found;
        hi       = '0;
        lo       = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int j = 0; j < NREQ_MAX; j++) begin
            if (j < nreq && req[j]) begin
                if (j >= int'(ptr) && !hi_found) begin
                    hi_found = 1'b1;
                    hi       = IDXW'(j);
                end
                if (!lo_found) begin
                    lo_found = 1'b1;
                    lo       = IDXW'(j);
                end
            end
        end
        return hi_found ? hi : lo;
    endfunction

endpackage

// File: rtl/video_umul_arbiter_sys_umul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
//   CLK_VIDEO : clock
//   mul_start : 1-cycle pulse, latches mul_arg1/mul_arg2 and begins
//   mul_run   : high for exactly WB cycles while the product is built
//   mul_arg1  : multiplicand (WA bits)
//   mul_arg2  : multiplier (WB bits)
//   mul_res   : product (WA+WB bits), valid once mul_run has fallen
// There is deliberately no reset: an operation in progress always runs to
// completion, and the arbiter waits for mul_run to fall before reusing it.
module sys_umul
    import video_umul_arb_pkg::*;
#(
    parameter int WA = 12,
    parameter int WB = 12
) (
    input  logic             CLK_VIDEO,
    input  logic             mul_start,
    output logic             mul_run,
    input  logic [WA-1:0]    mul_arg1,
    input  logic [WB-1:0]    mul_arg2,
    output logic [WA+WB-1:0] mul_res
);

    localparam int WR = WA + WB;
    localparam int CW = $clog2(WB + 1);

    logic [WR-1:0] acc;
    logic [WR-1:0] mcand;
    logic [WB-1:0] mplier;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLK_VIDEO) begin
        if (mul_start) begin
            acc     <= '0;
            mcand   <= WR'(mul_arg1);
            mplier  <= mul_arg2;
            cnt     <= CW'(WB);
            mul_run <= 1'b1;
        end else if (mul_run) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                mul_run <= 1'b0;
            end
        end
    end

    assign mul_res = acc;

endmodule

// File: rtl/video_umul_arbiter.sv
// Round-robin arbiter sharing one iterative multiplier among NREQ requesters.
//   CLK_VIDEO : video clock
//   RESET_N   : synchronous active-low reset
//   REQ       : per-requester request level
//   ARG1/ARG2 : packed operands, requester i at [i*WA +: WA] / [i*WB +: WB]
//   ACK       : 1-cycle pulse, operands of requester i have been latched
//   DONE      : 1-cycle pulse, RES holds requester i's product
//   RES       : product, held until the next DONE
//   BUSY      : high from grant until the DONE cycle
//   dbg_state : current FSM state, for observation only
//
// Handshake: a requester raises REQ with ARG1/ARG2 and holds all three stable
// until it sees ACK. Dropping REQ before ACK withdraws the request. Keeping REQ
// high after ACK queues another multiply; operands may change once ACK is seen.
// Only IDLE samples REQ, so edges during START/WAIT take effect at next IDLE.
module video_umul_arbiter
    import video_umul_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int WA   = 12,
    parameter int WB   = 12
) (
    input  logic                 CLK_VIDEO,
    input  logic                 RESET_N,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ*WA-1:0]   ARG1,
    input  logic [NREQ*WB-1:0]   ARG2,
    output logic [NREQ-1:0]      ACK,
    output logic [NREQ-1:0]      DONE,
    output logic [WA+WB-1:0]     RES,
    output logic                 BUSY,
    output state_t               dbg_state
);

    localparam int WR = WA + WB;

    state_t          state,    state_n;
    logic [IDXW-1:0] rr_ptr,   rr_n;
    logic [IDXW-1:0] idx,      idx_n;
    logic [WA-1:0]   mul_arg1, arg1_n;
    logic [WB-1:0]   mul_arg2, arg2_n;
    logic            mul_start, start_n;
    logic [NREQ-1:0] ack_n, done_n;
    logic [WR-1:0]   res_n;
    logic            busy_n;
    logic            mul_run;
    logic [WR-1:0]   mul_res;
    logic [IDXW-1:0] pick;

    assign pick      = rr_pick(NREQ_MAX'(REQ), rr_ptr, NREQ);
    assign dbg_state = state;

    sys_umul #(.WA(WA), .WB(WB)) u_mul (
        .CLK_VIDEO (CLK_VIDEO),
        .mul_start (mul_start),
        .mul_run   (mul_run),
        .mul_arg1  (mul_arg1),
        .mul_arg2  (mul_arg2),
        .mul_res   (mul_res)
    );

    always_comb begin
        state_n = state;
        rr_n    = rr_ptr;
        idx_n   = idx;
        arg1_n  = mul_arg1;
        arg2_n  = mul_arg2;
        start_n = 1'b0;
        ack_n   = '0;
        done_n  = '0;
        res_n   = RES;
        busy_n  = BUSY;
        case (state)
            IDLE: begin
                // The multiplier has no reset, so a product abandoned by a
                // reset may still be running; never start over it.
                if (!mul_run && |REQ) begin
                    idx_n = pick;
                    for (int i = 0; i < NREQ; i++) begin
                        if (pick == IDXW'(i)) begin
                            arg1_n   = ARG1[i*WA +: WA];
                            arg2_n   = ARG2[i*WB +: WB];
                            ack_n[i] = 1'b1;
                        end
                    end
                    start_n = 1'b1;
                    busy_n  = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                // mul_start is high during this cycle; mul_run rises after it.
                state_n = WAIT;
            end
            WAIT: begin
                if (!mul_run) begin
                    res_n = mul_res;
                    for (int i = 0; i < NREQ; i++) begin
                        if (idx == IDXW'(i)) begin
                            done_n[i] = 1'b1;
                        end
                    end
                    busy_n  = 1'b0;
                    rr_n    = (idx == IDXW'(NREQ - 1)) ? '0 : idx + IDXW'(1);
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_VIDEO) begin
        if (!RESET_N) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            idx       <= '0;
            mul_arg1  <= '0;
            mul_arg2  <= '0;
            mul_start <= 1'b0;
            ACK       <= '0;
            DONE      <= '0;
            RES       <= '0;
            BUSY      <= 1'b0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_n;
            idx       <= idx_n;
            mul_arg1  <= arg1_n;
            mul_arg2  <= arg2_n;
            mul_start <= start_n;
            ACK       <= ack_n;
            DONE      <= done_n;
            RES       <= res_n;
            BUSY      <= busy_n;
        end
    end

endmodule

// File: tb/tb_video_umul_arbiter.sv
// Bench for video_umul_arbiter: transaction-level reference model, table of
// single multiplies, hand-written corner sequences and a randomized phase.
module tb_video_umul_arbiter;
    import video_umul_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int WA   = 12;
    localparam int WB   = 12;
    localparam int WR   = WA + WB;
    localparam int L    = WB;   // cycles the multiplier keeps mul_run high

    logic               CLK_VIDEO = 1'b0;
    logic               RESET_N;
    logic [NREQ-1:0]    REQ;
    logic [NREQ*WA-1:0] ARG1;
    logic [NREQ*WB-1:0] ARG2;
    logic [NREQ-1:0]    ACK;
    logic [NREQ-1:0]    DONE;
    logic [WR-1:0]      RES;
    logic               BUSY;
    state_t             dbg_state;

    video_umul_arbiter #(.NREQ(NREQ), .WA(WA), .WB(WB)) dut (
        .CLK_VIDEO (CLK_VIDEO),
        .RESET_N   (RESET_N),
        .REQ       (REQ),
        .ARG1      (ARG1),
        .ARG2      (ARG2),
        .ACK       (ACK),
        .DONE      (DONE),
        .RES       (RES),
        .BUSY      (BUSY),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 CLK_VIDEO = ~CLK_VIDEO;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ack_cnt[NREQ];
    int done_cnt[NREQ];

    // ---------------- reference model ----------------
    // Cycle c means "outputs just after posedge c". A request seen at posedge p
    // while the arbiter is free gives ACK at p, DONE at p+L+2, next grant at
    // p+L+3 at the earliest; the multiplier itself is free again at p+L+2.
    int              free_at     = 0;
    int              mul_free_at = 0;
    int              ptr_m       = 0;
    logic [NREQ-1:0] exp_ack[int];
    logic [NREQ-1:0] exp_done[int];
    logic [WR-1:0]   exp_prod[int];
    int              exp_slot[int];
    bit              exp_rst[int];
    logic [WR-1:0]   res_m  = '0;
    logic            busy_m = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input int p);
        int            keys[$];
        int            s;
        logic [WA-1:0] a;
        logic [WB-1:0] b;
        if (!RESET_N) begin
            foreach (exp_done[k]) if (k >= p) keys.push_back(k);
            foreach (keys[i]) begin
                exp_done.delete(keys[i]);
                exp_prod.delete(keys[i]);
                exp_slot.delete(keys[i]);
            end
            exp_rst[p] = 1'b1;
            free_at    = p + 1;
            ptr_m      = 0;
        end else if (p >= free_at && p >= mul_free_at && REQ != '0) begin
            s = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (s < 0 && REQ[(ptr_m + k) % NREQ]) s = (ptr_m + k) % NREQ;
            end
            a = ARG1[s*WA +: WA];
            b = ARG2[s*WB +: WB];
            exp_ack[p]        = NREQ'(1) << s;
            exp_done[p+L+2]   = NREQ'(1) << s;
            exp_prod[p+L+2]   = WR'(longint'(a) * longint'(b));
            exp_slot[p+L+2]   = s;
            free_at           = p + L + 3;
            mul_free_at       = p + L + 2;
        end
    endtask

    task automatic check(input int c);
        logic [NREQ-1:0] ack_e;
        logic [NREQ-1:0] done_e;
        ack_e  = exp_ack.exists(c)  ? exp_ack[c]  : '0;
        done_e = exp_done.exists(c) ? exp_done[c] : '0;
        if (exp_rst.exists(c)) begin
            res_m  = '0;
            busy_m = 1'b0;
            cmp("rst_state", 32'(dbg_state), 32'(IDLE));
        end
        if (|ack_e) busy_m = 1'b1;
        if (|done_e) begin
            res_m  = exp_prod[c];
            busy_m = 1'b0;
            ptr_m  = (exp_slot[c] + 1) % NREQ;
        end
        cmp("ack",  32'(ACK),  32'(ack_e));
        cmp("done", 32'(DONE), 32'(done_e));
        cmp("res",  32'(RES),  32'(res_m));
        cmp("busy", 32'(BUSY), 32'(busy_m));
        cmp("ack_done_excl",
            32'($onehot0(ACK) && $onehot0(DONE) && !(|ACK && |DONE)), 32'd1);
        for (int i = 0; i < NREQ; i++) begin
            if (ACK[i])  ack_cnt[i]++;
            if (DONE[i]) done_cnt[i]++;
        end
    endtask

    task automatic tick();
        model_step(cyc + 1);
        @(posedge CLK_VIDEO);
        cyc++;
        @(negedge CLK_VIDEO);
        check(cyc);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic [WA-1:0] a, input logic [WB-1:0] b);
        REQ[i]           = 1'b1;
        ARG1[i*WA +: WA] = a;
        ARG2[i*WB +: WB] = b;
    endtask

    task automatic wait_ack(input int i, input int budget, output int c);
        c = -1;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (ACK[i]) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) cmp("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int i, input int budget, output int c);
        c = -1;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (DONE[i]) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) cmp("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset(input int n);
        RESET_N = 1'b0;
        for (int k = 0; k < n; k++) tick();
        RESET_N = 1'b1;
    endtask

    function automatic int slot_of(input logic [NREQ-1:0] v);
        int s;
        s = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) s = i;
        return s;
    endfunction

    function automatic logic [WA-1:0] rand_op();
        case ($urandom_range(5, 0))
            0:       return '0;
            1:       return '1;
            default: return WA'($urandom_range(4095, 0));
        endcase
    endfunction

    // ---------------- table of single multiplies ----------------
    typedef struct {
        int            slot;
        logic [WA-1:0] a;
        logic [WB-1:0] b;
        logic [WR-1:0] exp;
    } vec_t;
    vec_t vecs[8];

    // ---------------- test sequence ----------------
    initial begin
        int ack_c, done_c, req_c, a1, a2, n, d_before, a_before;
        int order[5];
        int aord[3];

        vecs[0] = '{0, 12'd4,     12'd3,     24'd12};
        vecs[1] = '{1, 12'd0,     12'd4095,  24'd0};
        vecs[2] = '{2, 12'd4095,  12'd4095,  24'hFFE001};
        vecs[3] = '{3, 12'd1024,  12'd1024,  24'h100000};
        vecs[4] = '{0, 12'd255,   12'd255,   24'd65025};
        vecs[5] = '{1, 12'hABC,   12'h123,   24'd799668};
        vecs[6] = '{2, 12'd1,     12'd4095,  24'd4095};
        vecs[7] = '{3, 12'd4095,  12'd0,     24'd0};

        for (int i = 0; i < NREQ; i++) begin
            ack_cnt[i]  = 0;
            done_cnt[i] = 0;
        end
        REQ     = '0;
        ARG1    = '0;
        ARG2    = '0;
        RESET_N = 1'b0;

        // 1: reset held three cycles with no requests
        do_reset(3);
        cmp("reset_busy", 32'(BUSY), 32'd0);

        // 2: table of single requests, one at a time
        foreach (vecs[v]) begin
            req_c = cyc;
            set_req(vecs[v].slot, vecs[v].a, vecs[v].b);
            wait_ack(vecs[v].slot, 40, ack_c);
            REQ = '0;
            ARG1[vecs[v].slot*WA +: WA] = rand_op();
            ARG2[vecs[v].slot*WB +: WB] = rand_op();
            wait_done(vecs[v].slot, 40, done_c);
            cmp("vec_res", 32'(RES), 32'(vecs[v].exp));
            cmp("vec_ack_lat", 32'(ack_c - req_c), 32'd1);
            cmp("vec_done_lat", 32'(done_c - ack_c), 32'(L + 2));
        end

        // 3: all four held, round-robin order from a fresh pointer
        do_reset(1);
        set_req(0, 12'd10,   12'd20);
        set_req(1, 12'd300,  12'd7);
        set_req(2, 12'd1234, 12'd56);
        set_req(3, 12'd4095, 12'd4095);
        n = 0;
        for (int k = 0; k < 5 * (L + 3) + 20 && n < 5; k++) begin
            tick();
            if (|DONE) begin
                order[n] = slot_of(DONE);
                if (order[n] == 3) cmp("slot3_res", 32'(RES), 32'hFFE001);
                n++;
            end
        end
        REQ = '0;
        cmp("rr_done_count", 32'(n), 32'd5);
        for (int j = 0; j < 5; j++) cmp("rr_order", 32'(order[j]), 32'(j % NREQ));
        for (int k = 0; k < L + 4; k++) tick();

        // 4: pointer wraps past slot 3 back to slot 0
        do_reset(1);
        set_req(2, 12'd9, 12'd9);
        wait_ack(2, 40, ack_c);
        aord[0] = 2;
        set_req(0, 12'd11, 12'd13);
        n = 1;
        for (int k = 0; k < 3 * (L + 3) + 10 && n < 3; k++) begin
            tick();
            if (|ACK) begin
                aord[n] = slot_of(ACK);
                n++;
            end
        end
        REQ = '0;
        cmp("wrap_ack_count", 32'(n), 32'd3);
        cmp("wrap_first", 32'(aord[1]), 32'd0);
        cmp("wrap_second", 32'(aord[2]), 32'd2);
        for (int k = 0; k < L + 4; k++) tick();

        // 5: zero operand; a request withdrawn before its ACK is never served
        set_req(0, 12'd0, 12'd4095);
        wait_ack(0, 40, ack_c);
        REQ[0]   = 1'b0;
        a_before = ack_cnt[1];
        d_before = done_cnt[1];
        set_req(1, 12'd5, 12'd6);
        for (int k = 0; k < 4; k++) tick();
        REQ[1] = 1'b0;
        wait_done(0, 40, done_c);
        cmp("zero_res", 32'(RES), 32'd0);
        for (int k = 0; k < L + 6; k++) tick();
        cmp("dropped_no_ack",  32'(ack_cnt[1] - a_before),  32'd0);
        cmp("dropped_no_done", 32'(done_cnt[1] - d_before), 32'd0);

        // 6: reset while waiting; next grant waits for the orphaned multiply
        set_req(1, 12'd123, 12'd45);
        wait_ack(1, 40, a1);
        REQ      = '0;
        d_before = done_cnt[1];
        for (int k = 0; k < 4; k++) tick();
        do_reset(1);
        cmp("rst_busy_clear", 32'(BUSY), 32'd0);
        set_req(2, 12'd77, 12'd88);
        wait_ack(2, 40, a2);
        REQ = '0;
        cmp("rst_ack_after_run", 32'(a2 - a1), 32'(L + 2));
        wait_done(2, 40, done_c);
        cmp("rst_new_res", 32'(RES), 32'd6776);
        cmp("rst_no_done", 32'(done_cnt[1] - d_before), 32'd0);

        // 7: randomized requesters with occasional withdrawals and resets
        for (int k = 0; k < 800; k++) begin
            tick();
            if ($urandom_range(299, 0) == 0) begin
                do_reset(1);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (REQ[i] && ACK[i]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        set_req(i, rand_op(), rand_op());
                    end else begin
                        REQ[i] = 1'b0;
                    end
                end else if (REQ[i]) begin
                    if ($urandom_range(19, 0) == 0) REQ[i] = 1'b0;
                end else if ($urandom_range(3, 0) == 0) begin
                    set_req(i, rand_op(), rand_op());
                end
            end
        end
        REQ = '0;
        for (int k = 0; k < L + 6; k++) tick();
        cmp("drain_busy", 32'(BUSY), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
